// File: rtl/io_bus_pkg.sv
// -----------------------------------------------------------------------------
// io_bus_pkg
// Shared definitions for the host I/O bus framer and its address decoder:
//   - status beat bit positions
//   - framer state encodings
//   - soft-reset address for the default 15-bit address width
//   - default peripheral window map (GPIO, UART, SPI, RAM, video)
// -----------------------------------------------------------------------------
package io_bus_pkg;

   // Status beat bit positions; all other status bits are zero.
   localparam int STAT_OK_BIT      = 0;
   localparam int STAT_TIMEOUT_BIT = 1;
   localparam int STAT_NODEC_BIT   = 2;

   // Framer state encodings.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RECV   = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_SEND   = 3'd4;

   // Writing this address triggers the soft-reset pulse (default width).
   localparam logic [14:0] SOFT_RESET_ADDR = 15'h7FFF;

   // Default window map, channel 0 in the least significant 16 bits.
   localparam int          DEF_NUM_CHANNELS = 5;
   localparam logic [79:0] DEF_CH_BASE  = {16'h0080, 16'h0030, 16'h0020, 16'h0010, 16'h0000};
   localparam logic [79:0] DEF_CH_LIMIT = {16'h0100, 16'h0080, 16'h0030, 16'h0020, 16'h0010};

endpackage

// File: rtl/io_addr_decoder.sv
// -----------------------------------------------------------------------------
// io_addr_decoder
// Combinational priority window match. Each channel owns the half-open range
// [base, limit) compared at 16 bits with the address zero-extended. When
// windows overlap the lowest channel index wins.
// Ports:
//   addr_i  in   ADDR_WIDTH    address to decode
//   sel_o   out  NUM_CHANNELS  one-hot matching window (all zero on miss)
//   hit_o   out  1             some window matched
// -----------------------------------------------------------------------------
module io_addr_decoder
   import io_bus_pkg::*;
#(
   parameter int                         ADDR_WIDTH   = 15,
   parameter int                         NUM_CHANNELS = DEF_NUM_CHANNELS,
   parameter logic [NUM_CHANNELS*16-1:0] CH_BASE      = DEF_CH_BASE,
   parameter logic [NUM_CHANNELS*16-1:0] CH_LIMIT     = DEF_CH_LIMIT
) (
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   output logic [NUM_CHANNELS-1:0] sel_o,
   output logic                    hit_o
);

   logic [15:0] addr16_s;

   assign addr16_s = 16'(addr_i);

   // Priority match: a window only claims the address if no lower one did.
   always_comb begin
      logic hit_v;
      logic match_v;
      hit_v = 1'b0;
      sel_o = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         match_v  = (addr16_s >= CH_BASE[i*16 +: 16]) && (addr16_s < CH_LIMIT[i*16 +: 16]);
         sel_o[i] = match_v & ~hit_v;
         hit_v    = hit_v | match_v;
      end
      hit_o = hit_v;
   end

endmodule

// File: rtl/io_bus_framer.sv
// -----------------------------------------------------------------------------
// io_bus_framer
// Collects a host request frame {write, addr, data} as REQ_BEATS serial beats
// (LSB beat first), decodes the address against NUM_CHANNELS windows, runs one
// request/acknowledge exchange with the selected peripheral (with timeout) and
// returns a status beat followed by DATA_WIDTH/BEAT_WIDTH data beats.
// Ports:
//   iBusClock    in   1                        clock, posedge
//   iBoardReset  in   1                        async active-low reset
//   iBusSelect   in   1                        frame enable; low aborts frame
//   iBusMOSI     in   BEAT_WIDTH               request beat
//   oBusMISO     out  BEAT_WIDTH               response beat
//   oBusReady    out  1                        oBusMISO valid
//   oReqValid    out  1                        peripheral request strobe
//   oReqWrite    out  1                        request write bit
//   oReqAddr     out  ADDR_WIDTH               request address
//   oReqData     out  DATA_WIDTH               write data
//   oChanEnable  out  NUM_CHANNELS             one-hot channel select
//   iAckValid    in   NUM_CHANNELS             per-channel acknowledge
//   iAckData     in   NUM_CHANNELS*DATA_WIDTH  per-channel read data
//   oSoftReset   out  1                        pulse on write to all-ones addr
// -----------------------------------------------------------------------------
module io_bus_framer
   import io_bus_pkg::*;
#(
   parameter int                         BEAT_WIDTH   = 8,
   parameter int                         ADDR_WIDTH   = 15,
   parameter int                         DATA_WIDTH   = 16,
   parameter int                         NUM_CHANNELS = DEF_NUM_CHANNELS,
   parameter logic [NUM_CHANNELS*16-1:0] CH_BASE      = DEF_CH_BASE,
   parameter logic [NUM_CHANNELS*16-1:0] CH_LIMIT     = DEF_CH_LIMIT,
   parameter int                         TIMEOUT      = 15
) (
   input  logic                           iBusClock,
   input  logic                           iBoardReset,
   input  logic                           iBusSelect,
   input  logic [BEAT_WIDTH-1:0]          iBusMOSI,
   output logic [BEAT_WIDTH-1:0]          oBusMISO,
   output logic                           oBusReady,
   output logic                           oReqValid,
   output logic                           oReqWrite,
   output logic [ADDR_WIDTH-1:0]          oReqAddr,
   output logic [DATA_WIDTH-1:0]          oReqData,
   output logic [NUM_CHANNELS-1:0]        oChanEnable,
   input  logic [NUM_CHANNELS-1:0]        iAckValid,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] iAckData,
   output logic                           oSoftReset
);

   localparam int FRAME_W    = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int REQ_BEATS  = FRAME_W / BEAT_WIDTH;
   localparam int DATA_BEATS = DATA_WIDTH / BEAT_WIDTH;
   localparam int CNT_W      = $clog2(REQ_BEATS + 1);
   localparam int SCNT_W     = $clog2(DATA_BEATS + 1);
   localparam int TCNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] SRST_ADDR = {ADDR_WIDTH{1'b1}};

   // Elaboration-time guards on the frame geometry.
   if ((FRAME_W % BEAT_WIDTH) != 0) begin : g_bad_frame
      $error("io_bus_framer: 1+ADDR_WIDTH+DATA_WIDTH must be a multiple of BEAT_WIDTH");
   end
   if ((DATA_WIDTH % BEAT_WIDTH) != 0) begin : g_bad_data
      $error("io_bus_framer: DATA_WIDTH must be a multiple of BEAT_WIDTH");
   end
   if (BEAT_WIDTH < 3) begin : g_bad_beat
      $error("io_bus_framer: BEAT_WIDTH too narrow for the status beat");
   end

   logic [2:0]              state_q,     state_d;
   logic [CNT_W-1:0]        beat_cnt_q,  beat_cnt_d;
   logic [FRAME_W-1:0]      frame_q,     frame_d;
   logic [TCNT_W-1:0]       wait_cnt_q,  wait_cnt_d;
   logic [SCNT_W-1:0]       send_cnt_q,  send_cnt_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
   logic [BEAT_WIDTH-1:0]   miso_q,      miso_d;
   logic                    ready_q,     ready_d;
   logic                    req_valid_q, req_valid_d;
   logic                    req_write_q, req_write_d;
   logic [ADDR_WIDTH-1:0]   req_addr_q,  req_addr_d;
   logic [DATA_WIDTH-1:0]   req_data_q,  req_data_d;
   logic [NUM_CHANNELS-1:0] chan_q,      chan_d;
   logic                    soft_rst_q,  soft_rst_d;

   logic [FRAME_W-1:0]      frame_shift_s;
   logic [DATA_WIDTH-1:0]   frame_data_s;
   logic [ADDR_WIDTH-1:0]   frame_addr_s;
   logic                    frame_write_s;
   logic [NUM_CHANNELS-1:0] dec_sel_s;
   logic                    dec_hit_s;
   logic                    ack_hit_s;
   logic [DATA_WIDTH-1:0]   ack_data_s;
   logic                    send_go_s;
   logic [BEAT_WIDTH-1:0]   status_s;
   logic [DATA_WIDTH-1:0]   rsp_load_s;

   // Beats enter at the top so the first (LSB) beat ends up at bit 0.
   assign frame_shift_s = {iBusMOSI, frame_q[FRAME_W-1:BEAT_WIDTH]};
   assign frame_data_s  = frame_q[DATA_WIDTH-1:0];
   assign frame_addr_s  = frame_q[DATA_WIDTH +: ADDR_WIDTH];
   assign frame_write_s = frame_q[FRAME_W-1];

   io_addr_decoder #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .NUM_CHANNELS (NUM_CHANNELS),
      .CH_BASE      (CH_BASE),
      .CH_LIMIT     (CH_LIMIT)
   ) u_decoder (
      .addr_i (frame_addr_s),
      .sel_o  (dec_sel_s),
      .hit_o  (dec_hit_s)
   );

   // Only the channel we selected may complete the request.
   assign ack_hit_s = |(iAckValid & chan_q);

   // Read-data mux driven by the registered one-hot select.
   always_comb begin
      ack_data_s = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         ack_data_s = ack_data_s | (iAckData[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{chan_q[i]}});
      end
   end

   // Next-state logic for the frame receive / decode / wait / send sequence.
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      frame_d     = frame_q;
      wait_cnt_d  = wait_cnt_q;
      send_cnt_d  = send_cnt_q;
      rsp_data_d  = rsp_data_q;
      miso_d      = miso_q;
      ready_d     = ready_q;
      req_valid_d = req_valid_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_data_d  = req_data_q;
      chan_d      = chan_q;
      soft_rst_d  = 1'b0;
      send_go_s   = 1'b0;
      status_s    = '0;
      rsp_load_s  = '0;

      case (state_q)
         ST_IDLE: begin
            if (iBusSelect) begin
               frame_d    = frame_shift_s;
               beat_cnt_d = CNT_W'(1);
               state_d    = ST_RECV;
            end else begin
               beat_cnt_d = '0;
            end
         end

         ST_RECV: begin
            if (!iBusSelect) begin
               state_d    = ST_IDLE;
               beat_cnt_d = '0;
            end else begin
               frame_d = frame_shift_s;
               if (beat_cnt_q == CNT_W'(REQ_BEATS - 1)) begin
                  state_d    = ST_DECODE;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end

         ST_DECODE: begin
            if (frame_write_s && (frame_addr_s == SRST_ADDR)) begin
               soft_rst_d             = 1'b1;
               send_go_s              = 1'b1;
               status_s[STAT_OK_BIT]  = 1'b1;
            end else if (dec_hit_s) begin
               req_valid_d = 1'b1;
               chan_d      = dec_sel_s;
               req_write_d = frame_write_s;
               req_addr_d  = frame_addr_s;
               req_data_d  = frame_data_s;
               wait_cnt_d  = '0;
               state_d     = ST_WAIT;
            end else begin
               send_go_s                = 1'b1;
               status_s[STAT_NODEC_BIT] = 1'b1;
            end
         end

         ST_WAIT: begin
            // Ack is checked before the timeout so a last-cycle ack still wins.
            if (ack_hit_s) begin
               req_valid_d           = 1'b0;
               chan_d                = '0;
               send_go_s             = 1'b1;
               status_s[STAT_OK_BIT] = 1'b1;
               rsp_load_s            = req_write_q ? '0 : ack_data_s;
            end else if (wait_cnt_q == TCNT_W'(TIMEOUT - 1)) begin
               req_valid_d                = 1'b0;
               chan_d                     = '0;
               send_go_s                  = 1'b1;
               status_s[STAT_TIMEOUT_BIT] = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + TCNT_W'(1);
            end
         end

         ST_SEND: begin
            // send_cnt_q counts data beats already presented after the status.
            if (!iBusSelect || (send_cnt_q == SCNT_W'(DATA_BEATS))) begin
               state_d    = ST_IDLE;
               ready_d    = 1'b0;
               miso_d     = '0;
               send_cnt_d = '0;
            end else begin
               miso_d     = rsp_data_q[BEAT_WIDTH-1:0];
               rsp_data_d = rsp_data_q >> BEAT_WIDTH;
               send_cnt_d = send_cnt_q + SCNT_W'(1);
            end
         end

         default: begin
            state_d     = ST_IDLE;
            ready_d     = 1'b0;
            req_valid_d = 1'b0;
            chan_d      = '0;
         end
      endcase

      // Common entry into SEND: the status beat is presented first.
      state_d    = send_go_s ? ST_SEND    : state_d;
      ready_d    = send_go_s ? 1'b1       : ready_d;
      miso_d     = send_go_s ? status_s   : miso_d;
      send_cnt_d = send_go_s ? '0         : send_cnt_d;
      rsp_data_d = send_go_s ? rsp_load_s : rsp_data_d;
   end

   // State and output registers; reset drops any in-flight request.
   always_ff @(posedge iBusClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         state_q     <= ST_IDLE;
         beat_cnt_q  <= '0;
         frame_q     <= '0;
         wait_cnt_q  <= '0;
         send_cnt_q  <= '0;
         rsp_data_q  <= '0;
         miso_q      <= '0;
         ready_q     <= 1'b0;
         req_valid_q <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
         chan_q      <= '0;
         soft_rst_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         frame_q     <= frame_d;
         wait_cnt_q  <= wait_cnt_d;
         send_cnt_q  <= send_cnt_d;
         rsp_data_q  <= rsp_data_d;
         miso_q      <= miso_d;
         ready_q     <= ready_d;
         req_valid_q <= req_valid_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_data_q  <= req_data_d;
         chan_q      <= chan_d;
         soft_rst_q  <= soft_rst_d;
      end
   end

   assign oBusMISO    = miso_q;
   assign oBusReady   = ready_q;
   assign oReqValid   = req_valid_q;
   assign oReqWrite   = req_write_q;
   assign oReqAddr    = req_addr_q;
   assign oReqData    = req_data_q;
   assign oChanEnable = chan_q;
   assign oSoftReset  = soft_rst_q;

endmodule
